// File: rtl/pipe_ctrl_pkg.sv
// Shared defines (register/XLEN ranges, state encodings) and the pipe_ctrl package.
// Compile this file first; the other pipe_ctrl files rely on its macros.
`ifndef PIPE_CTRL_DEFINES
`define PIPE_CTRL_DEFINES
`define REG_ADDR     4:0
`define XLEN_WIDTH   31:0
`define PIPE_ST_RUN    2'd0
`define PIPE_ST_LSTALL 2'd1
`define PIPE_ST_FLUSH  2'd2
`endif

package pipe_ctrl_pkg;
  localparam int REG_AW = 5;
  localparam int XLEN   = 32;

  typedef enum logic [1:0] {
    ST_RUN    = `PIPE_ST_RUN,
    ST_LSTALL = `PIPE_ST_LSTALL,
    ST_FLUSH  = `PIPE_ST_FLUSH
  } state_e;
endpackage

// File: rtl/pipe_ctrl_hazard_cmp.sv
// Combinational load-use comparator: flags an ID read of a register that the
// load currently in EX has not yet written back.
import pipe_ctrl_pkg::*;

module pipe_hazard_cmp (
  input  logic             ex_is_load,
  input  logic             ex_rd_en,
  input  logic [`REG_ADDR] ex_rd,
  input  logic [`REG_ADDR] id_rs1,
  input  logic             id_rs1_en,
  input  logic [`REG_ADDR] id_rs2,
  input  logic             id_rs2_en,
  output logic             hazard
);
  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_rs1_en && (id_rs1 == ex_rd);
  assign rs2_hit = id_rs2_en && (id_rs2 == ex_rd);
  // x0 is hardwired to zero, so a load targeting it never creates a dependency
  assign hazard  = ex_is_load && ex_rd_en && (ex_rd != '0) && (rs1_hit || rs2_hit);
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: busy stalls, jump flushes, load-use bubbles.
// Optional performance counters are enabled with the PIPE_CTRL_PERF_EN macro.
//
// state  | meaning
// RUN    | normal issue, load-use hazard evaluated
// LSTALL | bubble already inserted, hazard not re-evaluated
// FLUSH  | front end flushed for cnt more cycles after a jump
import pipe_ctrl_pkg::*;

module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [`REG_ADDR]   id_rs1,
  input  logic [`REG_ADDR]   id_rs2,
  input  logic               id_rs1_en,
  input  logic               id_rs2_en,
  input  logic [`REG_ADDR]   ex_rd,
  input  logic               ex_rd_en,
  input  logic               ex_is_load,
  input  logic               ex_busy,
  input  logic               jump_req,
  input  logic [`XLEN_WIDTH] jump_addr,
  output logic               pc_pause,
  output logic               if_id_pause,
  output logic               id_ex_pause,
  output logic               if_id_flush,
  output logic               id_ex_flush,
  output logic               pc_jump,
  output logic [`XLEN_WIDTH] pc_jump_addr,
`ifdef PIPE_CTRL_PERF_EN
  output logic [31:0]        stall_cnt,
  output logic [31:0]        flush_cnt,
`endif
  output logic [1:0]         state
);
  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       hazard;

  pipe_hazard_cmp u_hazard_cmp (
    .ex_is_load (ex_is_load),
    .ex_rd_en   (ex_rd_en),
    .ex_rd      (ex_rd),
    .id_rs1     (id_rs1),
    .id_rs1_en  (id_rs1_en),
    .id_rs2     (id_rs2),
    .id_rs2_en  (id_rs2_en),
    .hazard     (hazard)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_pause     = 1'b0;
    if_id_pause  = 1'b0;
    id_ex_pause  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    pc_jump      = 1'b0;
    pc_jump_addr = '0;
    if (rst) begin
      state_d = ST_RUN;
      cnt_d   = '0;
    end else if (ex_busy) begin
      pc_pause    = 1'b1;
      if_id_pause = 1'b1;
      id_ex_pause = 1'b1;
    end else if (jump_req) begin
      pc_jump      = 1'b1;
      pc_jump_addr = jump_addr;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      if (FLUSH_CYCLES <= 1) begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end else begin
        state_d = ST_FLUSH;
        cnt_d   = 2'(FLUSH_CYCLES - 1);
      end
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (hazard) begin
            pc_pause    = 1'b1;
            if_id_pause = 1'b1;
            id_ex_flush = 1'b1;
            state_d     = ST_LSTALL;
          end
        end
        ST_LSTALL: state_d = ST_RUN;
        ST_FLUSH: begin
          if_id_flush = 1'b1;
          if (cnt_q <= 2'd1) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state = rst ? 2'd0 : state_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // pc_pause/pc_jump are already zero during reset; counters wrap naturally
  always_comb begin
    stall_cnt_d = stall_cnt_q + 32'(pc_pause);
    flush_cnt_d = flush_cnt_q + 32'(pc_jump);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (FLUSH_CYCLES=3); perf counters checked when
// PIPE_CTRL_PERF_EN is defined.
import pipe_ctrl_pkg::*;

module tb_pipe_ctrl;
  logic              clk = 1'b0;
  logic              rst;
  logic [REG_AW-1:0] id_rs1, id_rs2, ex_rd;
  logic              id_rs1_en, id_rs2_en, ex_rd_en, ex_is_load, ex_busy, jump_req;
  logic [XLEN-1:0]   jump_addr;
  logic              pc_pause, if_id_pause, id_ex_pause, if_id_flush, id_ex_flush, pc_jump;
  logic [XLEN-1:0]   pc_jump_addr;
  logic [1:0]        state;
  logic [5:0]        outs;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0]       stall_cnt, flush_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.FLUSH_CYCLES(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_en    (id_rs1_en),
    .id_rs2_en    (id_rs2_en),
    .ex_rd        (ex_rd),
    .ex_rd_en     (ex_rd_en),
    .ex_is_load   (ex_is_load),
    .ex_busy      (ex_busy),
    .jump_req     (jump_req),
    .jump_addr    (jump_addr),
    .pc_pause     (pc_pause),
    .if_id_pause  (if_id_pause),
    .id_ex_pause  (id_ex_pause),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .pc_jump      (pc_jump),
    .pc_jump_addr (pc_jump_addr),
`ifdef PIPE_CTRL_PERF_EN
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
`endif
    .state        (state)
  );

  // {pc_pause, if_id_pause, id_ex_pause, if_id_flush, id_ex_flush, pc_jump}
  assign outs = {pc_pause, if_id_pause, id_ex_pause, if_id_flush, id_ex_flush, pc_jump};

  localparam logic [5:0] O_NONE  = 6'h00;
  localparam logic [5:0] O_STALL = 6'h32;
  localparam logic [5:0] O_BUSY  = 6'h38;
  localparam logic [5:0] O_JUMP  = 6'h07;
  localparam logic [5:0] O_FLUSH = 6'h04;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs are already applied just after a falling edge; check mid-cycle,
  // then advance to the next falling edge.
  task automatic cyc(input string tag, input logic [5:0] eo, input logic [1:0] es,
                     input logic [31:0] ea);
    #1;
    chk({tag, "_out"},   32'(outs),    32'(eo));
    chk({tag, "_state"}, 32'(state),   32'(es));
    chk({tag, "_addr"},  pc_jump_addr, ea);
    @(negedge clk);
  endtask

  task automatic idle();
    ex_busy = 0; jump_req = 0; jump_addr = '0;
    ex_is_load = 0; ex_rd_en = 0; ex_rd = '0;
    id_rs1 = '0; id_rs1_en = 0; id_rs2 = '0; id_rs2_en = 0;
  endtask

  task automatic set_hazard();
    ex_is_load = 1; ex_rd_en = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_en = 1;
  endtask

  initial begin
    rst = 1;
    idle();
    @(negedge clk);

    jump_req = 1; jump_addr = 32'h40; set_hazard();
    cyc("rst_jump", O_NONE, 2'd0, 32'h0);
    ex_busy = 1;
    cyc("rst_busy", O_NONE, 2'd0, 32'h0);
    rst = 0; idle();
    cyc("idle", O_NONE, 2'd0, 32'h0);

    set_hazard();
    cyc("lu_stall",  O_STALL, 2'd1 - 2'd1, 32'h0);
    cyc("lu_lstall", O_NONE,  2'd1, 32'h0);
    idle();
    cyc("lu_run",    O_NONE,  2'd0, 32'h0);

    ex_is_load = 1; ex_rd_en = 1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs1_en = 1;
    cyc("rd_zero", O_NONE, 2'd0, 32'h0);
    ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_en = 0;
    cyc("rs1_dis", O_NONE, 2'd0, 32'h0);
    id_rs2 = 5'd5; id_rs2_en = 1;
    cyc("rs2_stall",  O_STALL, 2'd0, 32'h0);
    cyc("rs2_lstall", O_NONE,  2'd1, 32'h0);
    ex_is_load = 0;
    cyc("not_load", O_NONE, 2'd0, 32'h0);
    ex_is_load = 1; ex_rd_en = 0;
    cyc("no_rd_en", O_NONE, 2'd0, 32'h0);

    idle(); jump_req = 1; jump_addr = 32'h40;
    cyc("j1", O_JUMP, 2'd0, 32'h40);
    jump_req = 0; jump_addr = '0; set_hazard();
    cyc("j1_f1", O_FLUSH, 2'd2, 32'h0);
    jump_req = 1; jump_addr = 32'h80;
    cyc("j2", O_JUMP, 2'd2, 32'h80);
    jump_req = 0; jump_addr = '0;
    cyc("j2_f1", O_FLUSH, 2'd2, 32'h0);
    idle();
    cyc("j2_f2", O_FLUSH, 2'd2, 32'h0);
    cyc("j2_run", O_NONE, 2'd0, 32'h0);

    ex_busy = 1; jump_req = 1; jump_addr = 32'h80; set_hazard();
    for (int i = 0; i < 4; i++) cyc("busy", O_BUSY, 2'd0, 32'h0);
    idle();
    cyc("busy_after", O_NONE, 2'd0, 32'h0);

    jump_req = 1; jump_addr = 32'h40;
    cyc("fb_jump", O_JUMP, 2'd0, 32'h40);
    jump_req = 0; jump_addr = '0; ex_busy = 1;
    cyc("fb_busy1", O_BUSY, 2'd2, 32'h0);
    cyc("fb_busy2", O_BUSY, 2'd2, 32'h0);
    ex_busy = 0;
    cyc("fb_f1", O_FLUSH, 2'd2, 32'h0);
    cyc("fb_f2", O_FLUSH, 2'd2, 32'h0);
    cyc("fb_run", O_NONE, 2'd0, 32'h0);

    jump_req = 1; jump_addr = 32'h40;
    cyc("rf_jump", O_JUMP, 2'd0, 32'h40);
    jump_req = 0; jump_addr = '0; rst = 1;
    cyc("rf_rst", O_NONE, 2'd0, 32'h0);
    rst = 0;
    cyc("rf_after", O_NONE, 2'd0, 32'h0);

`ifdef PIPE_CTRL_PERF_EN
    rst = 1;
    cyc("p_rst", O_NONE, 2'd0, 32'h0);
    rst = 0;
    chk("p_stall_rst", stall_cnt, 32'd0);
    chk("p_flush_rst", flush_cnt, 32'd0);
    set_hazard();
    cyc("p_st1", O_STALL, 2'd0, 32'h0);
    cyc("p_ls1", O_NONE,  2'd1, 32'h0);
    cyc("p_st2", O_STALL, 2'd0, 32'h0);
    cyc("p_ls2", O_NONE,  2'd1, 32'h0);
    idle(); ex_busy = 1;
    for (int i = 0; i < 3; i++) cyc("p_busy", O_BUSY, 2'd0, 32'h0);
    ex_busy = 0; jump_req = 1; jump_addr = 32'h40;
    cyc("p_jump", O_JUMP, 2'd0, 32'h40);
    idle();
    cyc("p_f1", O_FLUSH, 2'd2, 32'h0);
    cyc("p_f2", O_FLUSH, 2'd2, 32'h0);
    chk("p_stall_cnt", stall_cnt, 32'd5);
    chk("p_flush_cnt", flush_cnt, 32'd1);
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
    set_hazard();
    cyc("p_wrap", O_STALL, 2'd0, 32'h0);
    idle();
    #1;
    chk("p_stall_wrap", stall_cnt, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
